// File: rtl/alu_writeback.sv
// Write-back stage behind the f8 ALU: flag register, register-file write, 2-entry store queue.
// Define ALU_WB_MEM16_EN for a 16-bit data-memory port (single-beat wide stores, mem_wide present).
module alu_writeback #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] result_reg,
  input  logic [15:0] result_mem,
  input  logic        o_in,
  input  logic        z_in,
  input  logic        n_in,
  input  logic        c_in,
  input  logic [3:0]  flag_mask,
  input  logic        rf_we_in,
  input  logic [2:0]  rf_sel_in,
  input  logic        wide_in,
  input  logic        mem_we_in,
  input  logic [15:0] mem_addr_in,
  output logic        rf_we,
  output logic [2:0]  rf_sel,
  output logic        rf_wide,
  output logic [15:0] rf_data,
  output logic [3:0]  flags,
  output logic        c_to_alu,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
`ifdef ALU_WB_MEM16_EN
  output logic [15:0] mem_wdata,
  output logic        mem_wide
`else
  output logic [7:0]  mem_wdata
`endif
);

`ifdef ALU_WB_MEM16_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  logic          accept_s, push_s, pop_s, split_s, load_s, wr_idx_s;
  logic [1:0]    state_q, state_d, count_q, count_d;
  logic          head_q, head_d;
  logic [15:0]   qaddr_q [2];
  logic [15:0]   qaddr_d [2];
  logic [15:0]   qdata_q [2];
  logic [15:0]   qdata_d [2];
  logic [1:0]    qwide_q, qwide_d;
  logic [3:0]    flags_q, flags_d;
  logic          rf_we_q, rf_we_d, rf_wide_q, rf_wide_d;
  logic [2:0]    rf_sel_q, rf_sel_d;
  logic [15:0]   rf_data_q, rf_data_d;
  logic          mem_req_q, mem_req_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
`ifdef ALU_WB_MEM16_EN
  logic          mem_wide_q, mem_wide_d;
`endif

  assign in_ready  = (count_q != QDEPTH[1:0]);
  assign accept_s  = in_valid && in_ready;
  assign push_s    = accept_s && mem_we_in;
  assign flags     = flags_q;
  assign c_to_alu  = flags_q[0];
  assign rf_we     = rf_we_q;
  assign rf_sel    = rf_sel_q;
  assign rf_wide   = rf_wide_q;
  assign rf_data   = rf_data_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef ALU_WB_MEM16_EN
  assign mem_wide  = mem_wide_q;
`endif

  // Flag merge and register-file capture on accept.
  always_comb begin
    flags_d   = accept_s ? ((flags_q & ~flag_mask) | ({o_in, z_in, n_in, c_in} & flag_mask)) : flags_q;
    rf_we_d   = accept_s && rf_we_in;
    rf_sel_d  = accept_s ? rf_sel_in  : rf_sel_q;
    rf_wide_d = accept_s ? wide_in    : rf_wide_q;
    rf_data_d = accept_s ? result_reg : rf_data_q;
  end

  // Store-queue bookkeeping; the tail slot is head+count modulo 2.
  always_comb begin
`ifdef ALU_WB_MEM16_EN
    split_s = 1'b0;
`else
    split_s = (state_q == ST_LO) && qwide_q[head_q];
`endif
    pop_s    = mem_ack && (((state_q == ST_LO) && !split_s) || (state_q == ST_HI));
    wr_idx_s = head_q ^ count_q[0];
    for (int i = 0; i < 2; i++) begin
      qaddr_d[i] = (push_s && (wr_idx_s == 1'(i))) ? mem_addr_in : qaddr_q[i];
      qdata_d[i] = (push_s && (wr_idx_s == 1'(i))) ? result_mem  : qdata_q[i];
      qwide_d[i] = (push_s && (wr_idx_s == 1'(i))) ? wide_in     : qwide_q[i];
    end
    head_d  = pop_s ? ~head_q : head_q;
    count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
  end

  // Drain FSM; the next head is taken from the post-update queue so a push into an empty queue is requested immediately.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ALU_WB_MEM16_EN
    mem_wide_d  = mem_wide_q;
`endif
    load_s      = 1'b0;
    case (state_q)
      ST_IDLE: load_s = (count_d != 2'd0);
      ST_LO, ST_HI: begin
        if (!mem_ack) begin
          state_d = state_q;
        end else if (split_s) begin
          state_d    = ST_HI;
          mem_addr_d = qaddr_q[head_q] + 16'd1;
`ifdef ALU_WB_MEM16_EN
          mem_wdata_d = qdata_q[head_q];
`else
          mem_wdata_d = qdata_q[head_q][15:8];
`endif
        end else if (count_d != 2'd0) begin
          load_s = 1'b1;
        end else begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    if (load_s) begin
      state_d     = ST_LO;
      mem_req_d   = 1'b1;
      mem_addr_d  = qaddr_d[head_d];
      mem_wdata_d = qdata_d[head_d][DW-1:0];
`ifdef ALU_WB_MEM16_EN
      mem_wide_d  = qwide_d[head_d];
`endif
    end else begin
      load_s = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 2'd0;
      head_q      <= 1'b0;
      qaddr_q[0]  <= 16'h0000;
      qaddr_q[1]  <= 16'h0000;
      qdata_q[0]  <= 16'h0000;
      qdata_q[1]  <= 16'h0000;
      qwide_q     <= 2'b00;
      flags_q     <= 4'h0;
      rf_we_q     <= 1'b0;
      rf_sel_q    <= 3'd0;
      rf_wide_q   <= 1'b0;
      rf_data_q   <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= '0;
`ifdef ALU_WB_MEM16_EN
      mem_wide_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      qaddr_q     <= qaddr_d;
      qdata_q     <= qdata_d;
      qwide_q     <= qwide_d;
      flags_q     <= flags_d;
      rf_we_q     <= rf_we_d;
      rf_sel_q    <= rf_sel_d;
      rf_wide_q   <= rf_wide_d;
      rf_data_q   <= rf_data_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef ALU_WB_MEM16_EN
      mem_wide_q  <= mem_wide_d;
`endif
    end
  end

endmodule
